// File: rtl/alu_issue_unit.sv
// Issue/write-back sequencer around an external combinational 32-bit ALU with an 8x32 register file.
// Optional feature: define ALU_ISSUE_BYPASS_EN to accept on the write-back cycle and forward its result.
module alu_issue_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [10:0] instr,
  input  logic        load_en,
  input  logic [2:0]  load_addr,
  input  logic [31:0] load_data,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [1:0]  alu_op,
  input  logic [31:0] alu_result,
  output logic        done,
  output logic [2:0]  done_rd,
  output logic [31:0] done_data,
  output logic        load_conflict,
  input  logic [2:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WB    = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] rf_r [8];
  logic [2:0]  rd_r;
  logic [31:0] res_r;
  logic [31:0] opa_s, opb_s;
  logic        fire_s, wb_we_s, drop_s;
  logic [2:0]  rs1_s, rs2_s;

  assign rs1_s = instr[5:3];
  assign rs2_s = instr[2:0];

`ifdef ALU_ISSUE_BYPASS_EN
  assign instr_ready = (state_r == IDLE) || (state_r == WB);
`else
  assign instr_ready = (state_r == IDLE);
`endif

  assign fire_s  = instr_valid && instr_ready;
  assign wb_we_s = (state_r == WB) && (rd_r != 3'd0);
  // A load to the register being written back on the same edge loses.
  assign drop_s  = load_en && wb_we_s && (load_addr == rd_r);

  assign dbg_data = (dbg_addr == 3'd0) ? 32'd0 : rf_r[dbg_addr];

  // Next-state logic for the issue sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (fire_s) state_s = ISSUE;
        else        state_s = IDLE;
      end
      ISSUE: state_s = WB;
      WB: begin
        if (fire_s) state_s = ISSUE;
        else        state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Operand selection: array read, r0 forced to zero, optional forwarding of the completing result.
  always_comb begin
    opa_s = (rs1_s == 3'd0) ? 32'd0 : rf_r[rs1_s];
    opb_s = (rs2_s == 3'd0) ? 32'd0 : rf_r[rs2_s];
`ifdef ALU_ISSUE_BYPASS_EN
    if (wb_we_s && (rs1_s == rd_r)) opa_s = res_r;
    else                            opa_s = opa_s;
    if (wb_we_s && (rs2_s == rd_r)) opb_s = res_r;
    else                            opb_s = opb_s;
`endif
  end

  // Register file: load port and write-back port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) rf_r[i] <= 32'd0;
    end else begin
      if (load_en && (load_addr != 3'd0) && !drop_s) rf_r[load_addr] <= load_data;
      if (wb_we_s) rf_r[rd_r] <= res_r;
    end
  end

  // Sequencer state, ALU operand registers, result capture and completion outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      alu_a         <= 32'd0;
      alu_b         <= 32'd0;
      alu_op        <= 2'b00;
      rd_r          <= 3'd0;
      res_r         <= 32'd0;
      done          <= 1'b0;
      done_rd       <= 3'd0;
      done_data     <= 32'd0;
      load_conflict <= 1'b0;
    end else begin
      state_r       <= state_s;
      load_conflict <= drop_s;
      done          <= (state_r == ISSUE);
      if (fire_s) begin
        alu_a  <= opa_s;
        alu_b  <= opb_s;
        alu_op <= instr[10:9];
        rd_r   <= instr[8:6];
      end
      if (state_r == ISSUE) begin
        res_r     <= alu_result;
        done_rd   <= rd_r;
        done_data <= alu_result;
      end
    end
  end

endmodule

// File: doc/alu_issue_unit.md
# alu_issue_unit

Instruction sequencer that sits directly upstream and downstream of the 32-bit combinational ALU (2-bit opcode: 00 add, 01 sub, 10 shl, 11 shr). It accepts a register-to-register instruction over a valid/ready handshake. It reads two operands from an internal 8×32 register file and drives them to the ALU. It then captures the ALU result and writes it back, signalling completion. A side-band load port initialises register contents.

## Interface
Parameters:
- none (register count 8, data width 32, fixed)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
- instr_valid  in  1  instruction present
- instr_ready  out  1  unit can accept an instruction this cycle
- instr  in  11  [10:9] opcode, [8:6] rd, [5:3] rs1, [2:0] rs2
- load_en  in  1  write load_data into register load_addr this cycle
- load_addr  in  3  load target register
- load_data  in  32  load value
- alu_a  out  32  registered operand A to ALU
- alu_b  out  32  registered operand B to ALU
- alu_op  out  2  registered opcode to ALU
- alu_result  in  32  combinational ALU result for alu_a/alu_b/alu_op
- done  out  1  one-cycle pulse: write-back occurring
- done_rd  out  3  destination of completing instruction (valid with done)
- done_data  out  32  value written back (valid with done)
- load_conflict  out  1  one-cycle pulse: load dropped due to write-back collision
- dbg_addr  in  3  debug read address
- dbg_data  out  32  combinational read of register dbg_addr

## Operation
- Register r0 reads as 0 always; writes to r0 (load or write-back) are discarded, done still pulses.
- FSM states IDLE, ISSUE, WB.
  - IDLE: instr_ready=1. On instr_valid&&instr_ready, load alu_a=rf[rs1], alu_b=rf[rs2], alu_op=opcode, latch rd. Next state ISSUE.
  - ISSUE: instr_ready=0. The ALU evaluates combinationally. At the edge, capture alu_result into res_q. Next state WB.
  - WB: instr_ready=0. done=1, done_rd=rd, done_data=res_q. rf[rd]←res_q at the edge. Next state IDLE.
- Operand reads in IDLE see register contents before any same-edge load; there is no load-to-read forwarding.
- Load port: load_en writes rf[load_addr]←load_data in any state.
- Write-back and load collision, same edge, same nonzero address: write-back wins, the load is dropped, load_conflict=1 next cycle.
- Collision on different addresses: both writes complete.
- Shift amounts pass through unmodified; the ALU defines the shift semantics.
- Arithmetic wraps modulo 2^32; the block performs no arithmetic itself.
- Reset (any state, including mid-instruction):
  - state←IDLE; all registers r0–r7←0.
  - alu_a, alu_b←0; alu_op←00.
  - done, done_rd, done_data, load_conflict←0.
  - The in-flight instruction is discarded with no write-back.
  - instr_ready=1 in the first cycle after reset deasserts.

## Timing
- Handshake: transfer on a rising edge with instr_valid&&instr_ready. instr must be stable while valid and not yet accepted.
- Instruction latency, base build: accept at edge 0; ALU inputs valid after edge 0; result captured at edge 1; done high between edges 1 and 2; rf updated at edge 2.
- Throughput, base build: one instruction per 3 cycles.
- done, done_rd, done_data, load_conflict are registered outputs.
- dbg_data is combinational from the register array (post-edge value).

## Configuration
- ALU_ISSUE_BYPASS_EN defined:
  - instr_ready=1 also in WB, so a new instruction may be accepted on the write-back edge.
  - If that instruction's rs1 or rs2 equals the completing rd (rd≠0), the operand takes res_q instead of the array value.
  - Back-to-back throughput: one instruction per 2 cycles.
  - Load-vs-write-back priority is unchanged; bypass uses res_q even if a load targeted the same register.
- ALU_ISSUE_BYPASS_EN undefined: instr_ready=1 only in IDLE, with no forwarding, as described above.

## Test plan
- Reset: drive rst_n=0 for 2 cycles from mid-ISSUE, then release.
  - All outputs must be 0 and instr_ready=1.
  - dbg reads of r1–r7 must return 0, and no done pulse may occur.
- Add: load r1=5, r2=7; issue {00,r3,r1,r2}.
  - Require alu_a=5, alu_b=7 one cycle after accept.
  - done on the 2nd cycle after accept with done_rd=3, done_data=12; r3 reads 12 afterward.
- Sub wrap: r1=0, r2=1; issue {01,r4,r1,r2}.
  - Require done_data=0xFFFFFFFF.
- r0 handling: issue {00,r0,r1,r2} with r1=3, r2=4.
  - done pulses with done_data=7, but r0 still reads 0.
  - Issue {10,r5,r0,r1}; require alu_a=0.
- Collision: load r3=0xAAAA asserted on the WB edge of an instruction writing r3 with result 9.
  - r3 must read 9 and load_conflict must pulse once.
  - Repeat with load to r6: both writes succeed and there is no pulse.
- Back-to-back dependence: r1=2, r2=3; issue {00,r3,r1,r2} then {10,r4,r3,r1} with instr_valid held high.
  - Without the macro: second accept occurs 3 cycles after the first; r4=20.
  - With ALU_ISSUE_BYPASS_EN: second accept occurs 2 cycles after the first, alu_a=5 is forwarded, and r4=20.
